// File: rtl/multdiv_issue_ctrl.sv
// Purpose : execute-stage issue controller for the iterative multiply/divide unit.
// Latency : start at cycle 0, launch pulse at 1, busy from 2; result-ready at N gives writeback at N+1.
// Backpres: holds the upstream pipeline via stall from request acceptance until the writeback cycle.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start_mult/div      request strobes (multiply wins if both are high)
//   in_a, in_b, in_rd   operands and destination register, latched on acceptance
//   flush               kills an operation in LAUNCH/BUSY; also blocks a same-cycle start
//   md_resultRDY, md_result, md_exception   completion handshake from the unit
//   ctrl_MULT/ctrl_DIV  one-cycle launch pulses; counter_clear clears the unit counter
//   op_a, op_b          latched operands, held until the next accepted start
//   stall               combinational freeze for the upstream pipeline
//   wb_valid/we/rd/data single-cycle writeback, redirected to STATUS_REG on exception
//   timeout_err         sticky watchdog error
//
// Build option: define MD_TIMEOUT_EN to add a BUSY watchdog of TIMEOUT_CYCLES cycles.
// Without it the controller waits for the unit indefinitely and timeout_err is 0.

module multdiv_issue_ctrl #(
    parameter logic [31:0] EXC_MULT_CODE  = 32'd4,
    parameter logic [31:0] EXC_DIV_CODE   = 32'd5,
    parameter logic [4:0]  STATUS_REG     = 5'd30,
    parameter int unsigned TIMEOUT_CYCLES = 40
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start_mult,
    input  logic        start_div,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic [4:0]  in_rd,
    input  logic        flush,
    input  logic        md_resultRDY,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    output logic        ctrl_MULT,
    output logic        ctrl_DIV,
    output logic        counter_clear,
    output logic [31:0] op_a,
    output logic [31:0] op_b,
    output logic        stall,
    output logic        wb_valid,
    output logic        wb_we,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_BUSY   = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_op_a;
    logic [31:0] r_op_b;
    logic [4:0]  r_rd;
    logic        r_is_div;
    logic [31:0] r_result;
    logic        r_exc;

    logic        w_start;
    logic        w_accept;
    logic        w_capture;
    logic        w_expire;

    logic        w_ctrl_mult;
    logic        w_ctrl_div;
    logic        w_clear;
    logic        w_stall;
    logic        w_wb_valid;
    logic        w_wb_we;
    logic [4:0]  w_wb_rd;
    logic [31:0] w_wb_data;
    logic        w_timeout_err;

    assign w_start = start_mult | start_div;

    // A new request is taken in IDLE, or in DONE so a dependent op can issue
    // back-to-back with the writeback. flush kills the requesting instruction.
    assign w_accept = ((r_state == ST_IDLE) || (r_state == ST_DONE)) && w_start && !flush;

    // Result capture only while BUSY; a flush in the same cycle discards it.
    assign w_capture = (r_state == ST_BUSY) && md_resultRDY && !flush;

`ifdef MD_TIMEOUT_EN
    localparam logic [5:0] LP_WDOG_LAST = 6'(TIMEOUT_CYCLES - 1);

    logic [5:0] r_wdog;
    logic       r_timeout_err;

    // r_wdog counts completed BUSY cycles, so the current BUSY cycle is number
    // r_wdog+1. Expiry fires on the TIMEOUT_CYCLES-th BUSY cycle, unless the
    // unit answers in that same cycle (normal result wins) or it is flushed.
    assign w_expire = (r_state == ST_BUSY) && !md_resultRDY && !flush &&
                      (r_wdog == LP_WDOG_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wdog <= '0;
        end else if (r_state == ST_LAUNCH) begin
            r_wdog <= '0;
        end else if (r_state == ST_BUSY) begin
            r_wdog <= r_wdog + 6'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_timeout_err <= 1'b0;
        end else if (w_expire) begin
            r_timeout_err <= 1'b1;
        end
    end

    assign w_timeout_err = r_timeout_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT_CYCLES != 0);
    assign w_expire         = 1'b0;
    assign w_timeout_err    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Request latch and result capture
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_rd     <= '0;
            r_is_div <= 1'b0;
        end else if (w_accept) begin
            r_op_a   <= in_a;
            r_op_b   <= in_b;
            r_rd     <= in_rd;
            // multiply has priority when both strobes are high
            r_is_div <= start_div & ~start_mult;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_result <= '0;
            r_exc    <= 1'b0;
        end else if (w_capture) begin
            r_result <= md_result;
            r_exc    <= md_exception;
        end else if (w_expire) begin
            r_result <= '0;
            r_exc    <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Next state and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_ctrl_mult = 1'b0;
        w_ctrl_div  = 1'b0;
        w_clear     = 1'b0;
        w_stall     = 1'b0;
        w_wb_valid  = 1'b0;
        w_wb_we     = 1'b0;
        w_wb_rd     = '0;
        w_wb_data   = '0;

        case (r_state)
            ST_IDLE: begin
                // stall raised in the request cycle itself so the requesting
                // instruction stays in execute while the unit works
                w_stall = w_start;
                if (w_accept) begin
                    w_state_nxt = ST_LAUNCH;
                end
            end

            ST_LAUNCH: begin
                w_ctrl_mult = ~r_is_div;
                w_ctrl_div  = r_is_div;
                w_clear     = 1'b1;
                w_stall     = 1'b1;
                // md_resultRDY may still reflect the previous op here; ignore it
                w_state_nxt = flush ? ST_IDLE : ST_BUSY;
            end

            ST_BUSY: begin
                w_stall = 1'b1;
                if (flush) begin
                    w_state_nxt = ST_IDLE;
                end else if (md_resultRDY || w_expire) begin
                    w_state_nxt = ST_DONE;
                end
            end

            ST_DONE: begin
                w_wb_valid = 1'b1;
                if (r_exc) begin
                    w_wb_we   = 1'b1;
                    w_wb_rd   = STATUS_REG;
                    w_wb_data = r_is_div ? EXC_DIV_CODE : EXC_MULT_CODE;
                end else begin
                    w_wb_we   = (r_rd != 5'd0);
                    w_wb_rd   = r_rd;
                    w_wb_data = r_result;
                end
                w_state_nxt = w_accept ? ST_LAUNCH : ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // While reset is held everything is quiet except the counter clear,
        // which keeps the unit's counter parked; a pending writeback is dropped.
        if (reset) begin
            w_state_nxt = ST_IDLE;
            w_ctrl_mult = 1'b0;
            w_ctrl_div  = 1'b0;
            w_clear     = 1'b1;
            w_stall     = 1'b0;
            w_wb_valid  = 1'b0;
            w_wb_we     = 1'b0;
            w_wb_rd     = '0;
            w_wb_data   = '0;
        end
    end

    assign ctrl_MULT     = w_ctrl_mult;
    assign ctrl_DIV      = w_ctrl_div;
    assign counter_clear = w_clear;
    assign stall         = w_stall;
    assign wb_valid      = w_wb_valid;
    assign wb_we         = w_wb_we;
    assign wb_rd         = w_wb_rd;
    assign wb_data       = w_wb_data;
    assign op_a          = r_op_a;
    assign op_b          = r_op_b;
    assign timeout_err   = w_timeout_err;

endmodule

// File: tb/tb_multdiv_issue_ctrl.sv
module tb_multdiv_issue_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        start_mult, start_div;
    logic [31:0] in_a, in_b;
    logic [4:0]  in_rd;
    logic        flush;
    logic        md_resultRDY;
    logic [31:0] md_result;
    logic        md_exception;
    logic        ctrl_MULT, ctrl_DIV, counter_clear;
    logic [31:0] op_a, op_b;
    logic        stall, wb_valid, wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        timeout_err;

    always #5 clock = ~clock;

    multdiv_issue_ctrl dut (
        .clock(clock), .reset(reset),
        .start_mult(start_mult), .start_div(start_div),
        .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .flush(flush),
        .md_resultRDY(md_resultRDY), .md_result(md_result), .md_exception(md_exception),
        .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV), .counter_clear(counter_clear),
        .op_a(op_a), .op_b(op_b), .stall(stall),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
        .timeout_err(timeout_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Each cycle: drive just after posedge, check at negedge, then advance.
    task automatic sample();
        @(negedge clock);
    endtask

    task automatic advance();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        start_mult   = 1'b0;
        start_div    = 1'b0;
        flush        = 1'b0;
        md_resultRDY = 1'b0;
        md_exception = 1'b0;
    endtask

    // Expected writeback from the architectural rules (status codes 4/5 to reg 30)
    function automatic logic [31:0] exp_data(input logic is_div, input logic exc, input logic [31:0] res);
        if (exc) return is_div ? 32'd5 : 32'd4;
        return res;
    endfunction

    function automatic logic [4:0] exp_rd(input logic exc, input logic [4:0] rd);
        return exc ? 5'd30 : rd;
    endfunction

    typedef struct {
        logic        mult;
        logic        div;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        int          rdy_cyc;
        logic [31:0] res;
        logic        exc;
        logic        x_div;
        logic [4:0]  x_rd;
        logic [31:0] x_data;
        logic        x_we;
    } vec_t;

    vec_t vecs[5];

    task automatic run_vec(input vec_t v);
        start_mult = v.mult; start_div = v.div;
        in_a = v.a; in_b = v.b; in_rd = v.rd;
        sample();
        chk("vec_req_stall", stall, 1);
        chk("vec_req_ctrl", {ctrl_MULT, ctrl_DIV}, 0);
        advance();
        idle_inputs();
        for (int c = 1; c <= v.rdy_cyc; c++) begin
            if (c == v.rdy_cyc) begin
                md_resultRDY = 1'b1; md_result = v.res; md_exception = v.exc;
            end
            sample();
            chk("vec_stall", stall, 1);
            chk("vec_wbv_busy", wb_valid, 0);
            if (c == 1) begin
                chk("vec_ctrl_mult", ctrl_MULT, !v.x_div);
                chk("vec_ctrl_div", ctrl_DIV, v.x_div);
                chk("vec_clear", counter_clear, 1);
                chk("vec_op_a", op_a, v.a);
                chk("vec_op_b", op_b, v.b);
            end else begin
                chk("vec_ctrl_quiet", {ctrl_MULT, ctrl_DIV}, 0);
                chk("vec_clear_quiet", counter_clear, 0);
            end
            advance();
        end
        idle_inputs();
        sample();
        chk("vec_wb_valid", wb_valid, 1);
        chk("vec_wb_rd", wb_rd, v.x_rd);
        chk("vec_wb_data", wb_data, v.x_data);
        chk("vec_wb_we", wb_we, v.x_we);
        chk("vec_done_stall", stall, 0);
        advance();
        sample();
        chk("vec_wb_once", wb_valid, 0);
        advance();
    endtask

    task automatic rand_txn();
        int          gap, kind, n, fc;
        logic [31:0] a, b, res;
        logic [4:0]  rd;
        logic        exc, fl, is_div, flushed;
        gap  = $urandom_range(0, 2);
        kind = $urandom_range(0, 2);
        a    = $urandom; b = $urandom; res = $urandom;
        rd   = 5'($urandom_range(0, 31));
        n    = $urandom_range(2, 20);
        exc  = ($urandom_range(0, 3) == 0);
        fl   = ($urandom_range(0, 4) == 0);
        fc   = $urandom_range(1, n);
        is_div  = (kind == 1);
        flushed = 1'b0;
        for (int g = 0; g < gap; g++) begin
            idle_inputs();
            sample();
            chk("rnd_idle_stall", stall, 0);
            chk("rnd_idle_wbv", wb_valid, 0);
            advance();
        end
        start_mult = (kind != 1); start_div = (kind != 0);
        in_a = a; in_b = b; in_rd = rd;
        sample();
        chk("rnd_req_stall", stall, 1);
        advance();
        for (int c = 1; c <= n; c++) begin
            // stray requests and noise on the unit interface must be ignored
            start_mult   = 1'($urandom_range(0, 1));
            start_div    = 1'($urandom_range(0, 1));
            in_a         = $urandom; in_b = $urandom;
            in_rd        = 5'($urandom_range(0, 31));
            md_resultRDY = (c == n) ? 1'b1 : ((c == 1) ? 1'($urandom_range(0, 1)) : 1'b0);
            md_result    = (c == n) ? res : $urandom;
            md_exception = (c == n) ? exc : 1'($urandom_range(0, 1));
            flush        = fl && (c == fc);
            sample();
            chk("rnd_stall", stall, 1);
            chk("rnd_wbv_busy", wb_valid, 0);
            chk("rnd_op_a", op_a, a);
            chk("rnd_op_b", op_b, b);
            if (c == 1) chk("rnd_ctrl", {ctrl_MULT, ctrl_DIV}, is_div ? 2'b01 : 2'b10);
            else        chk("rnd_ctrl_quiet", {ctrl_MULT, ctrl_DIV}, 0);
            advance();
            if (flush) begin
                flushed = 1'b1;
                break;
            end
        end
        idle_inputs();
        sample();
        chk("rnd_after_stall", stall, 0);
        chk("rnd_after_ctrl", {ctrl_MULT, ctrl_DIV}, 0);
        if (flushed) begin
            chk("rnd_flush_nowb", wb_valid, 0);
        end else begin
            chk("rnd_wbv", wb_valid, 1);
            chk("rnd_wb_rd", wb_rd, exp_rd(exc, rd));
            chk("rnd_wb_data", wb_data, exp_data(is_div, exc, res));
            chk("rnd_wb_we", wb_we, exc || (rd != 0));
        end
        advance();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got stuck required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{1, 0, 32'd6,   32'd7, 5'd3,  16, 32'd42,        0, 0, 5'd3,  32'd42,        1};
        vecs[1] = '{0, 1, 32'd100, 32'd0, 5'd8,  10, 32'hdead,      1, 1, 5'd30, 32'd5,         1};
        vecs[2] = '{1, 0, 32'h8000_0000, 32'd2, 5'd8, 5, 32'd0,     1, 0, 5'd30, 32'd4,         1};
        vecs[3] = '{1, 1, 32'd3,   32'd4, 5'd0,  3,  32'd12,        0, 0, 5'd0,  32'd12,        0};
        vecs[4] = '{0, 1, 32'd50,  32'd7, 5'd31, 2,  32'd7,         0, 1, 5'd31, 32'd7,         1};

        idle_inputs();
        in_a = 0; in_b = 0; in_rd = 0; md_result = 0;
        reset = 1'b1;
        advance();
        advance();
        sample();
        chk("rst_clear", counter_clear, 1);
        chk("rst_stall", stall, 0);
        chk("rst_ctrl", {ctrl_MULT, ctrl_DIV}, 0);
        chk("rst_wbv", wb_valid, 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_op_b", op_b, 0);
        chk("rst_wb_rd", wb_rd, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_terr", timeout_err, 0);
        advance();
        reset = 1'b0;
        sample();
        chk("rst_release_clear", counter_clear, 0);
        advance();

        foreach (vecs[i]) run_vec(vecs[i]);

        // flush beats a start in IDLE
        start_mult = 1; flush = 1; in_a = 32'h77; in_rd = 5'd2;
        advance();
        idle_inputs();
        sample();
        chk("idle_flush_noctrl", ctrl_MULT, 0);
        chk("idle_flush_nostall", stall, 0);
        advance();

        // back-to-back: new start in DONE, RDY held high through LAUNCH
        start_mult = 1; in_a = 32'h10; in_b = 32'h11; in_rd = 5'd2;
        advance();
        idle_inputs();
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) begin md_resultRDY = 1; md_result = 32'h11; end
            advance();
        end
        idle_inputs();
        start_div = 1; in_a = 32'h20; in_b = 32'h21; in_rd = 5'd6;
        sample();
        chk("b2b_wbv", wb_valid, 1);
        chk("b2b_wb_data", wb_data, 32'h11);
        chk("b2b_done_stall", stall, 0);
        advance();
        idle_inputs();
        md_resultRDY = 1; md_result = 32'hbad;
        sample();
        chk("b2b_ctrl_div", ctrl_DIV, 1);
        chk("b2b_ctrl_mult", ctrl_MULT, 0);
        chk("b2b_stall", stall, 1);
        chk("b2b_op_a", op_a, 32'h20);
        advance();
        md_resultRDY = 0;
        sample();
        chk("b2b_launch_rdy_ignored", wb_valid, 0);
        chk("b2b_busy_stall", stall, 1);
        advance();
        md_resultRDY = 1; md_result = 32'h99;
        advance();
        idle_inputs();
        sample();
        chk("b2b2_wbv", wb_valid, 1);
        chk("b2b2_wb_rd", wb_rd, 6);
        chk("b2b2_wb_data", wb_data, 32'h99);
        advance();

        // flush together with RDY in BUSY
        start_div = 1; in_a = 32'h5; in_b = 32'h6; in_rd = 5'd4;
        advance();
        idle_inputs();
        advance();
        advance();
        flush = 1; md_resultRDY = 1; md_result = 32'h1234;
        sample();
        chk("flush_busy_stall", stall, 1);
        advance();
        idle_inputs();
        sample();
        chk("flush_nowb", wb_valid, 0);
        chk("flush_idle_stall", stall, 0);
        advance();
        sample();
        chk("flush_nowb2", wb_valid, 0);
        advance();

        // reset while BUSY with a result arriving
        start_mult = 1; in_a = 32'h9; in_b = 32'h9; in_rd = 5'd5;
        advance();
        idle_inputs();
        advance();
        advance();
        reset = 1; md_resultRDY = 1; md_result = 32'h81;
        sample();
        chk("rstbusy_clear", counter_clear, 1);
        advance();
        md_resultRDY = 0;
        sample();
        chk("rstbusy_clear2", counter_clear, 1);
        chk("rstbusy_stall", stall, 0);
        chk("rstbusy_wbv", wb_valid, 0);
        chk("rstbusy_op_a", op_a, 0);
        chk("rstbusy_ctrl", {ctrl_MULT, ctrl_DIV}, 0);
        advance();
        reset = 0;
        sample();
        chk("rstbusy_release_clear", counter_clear, 0);
        chk("rstbusy_nowb", wb_valid, 0);
        chk("rstbusy_idle_stall", stall, 0);
        advance();

        for (int t = 0; t < 60; t++) rand_txn();

`ifdef MD_TIMEOUT_EN
        // RDY on the 40th BUSY cycle wins over expiry
        start_mult = 1; in_rd = 5'd7; in_a = 1; in_b = 2;
        advance();
        idle_inputs();
        for (int c = 1; c <= 41; c++) begin
            if (c == 41) begin md_resultRDY = 1; md_result = 32'h55; end
            sample();
            chk("to_rdy_nowb", wb_valid, 0);
            advance();
        end
        idle_inputs();
        sample();
        chk("to_rdy_wbv", wb_valid, 1);
        chk("to_rdy_wb_rd", wb_rd, 7);
        chk("to_rdy_wb_data", wb_data, 32'h55);
        chk("to_rdy_terr", timeout_err, 0);
        advance();

        // no RDY: expiry after the 40th BUSY cycle
        start_div = 1; in_rd = 5'd9;
        advance();
        idle_inputs();
        for (int c = 1; c <= 41; c++) begin
            sample();
            chk("to_stall", stall, 1);
            chk("to_nowb", wb_valid, 0);
            advance();
        end
        sample();
        chk("to_wbv", wb_valid, 1);
        chk("to_wb_rd", wb_rd, 30);
        chk("to_wb_data", wb_data, 5);
        chk("to_wb_we", wb_we, 1);
        chk("to_terr", timeout_err, 1);
        advance();
        for (int c = 0; c < 3; c++) begin
            sample();
            chk("to_terr_sticky", timeout_err, 1);
            advance();
        end
        reset = 1;
        advance();
        reset = 0;
        sample();
        chk("to_terr_cleared", timeout_err, 0);
        advance();
`else
        // without the watchdog BUSY waits indefinitely
        start_mult = 1; in_rd = 5'd7;
        advance();
        idle_inputs();
        for (int c = 1; c <= 60; c++) advance();
        sample();
        chk("nowd_stall", stall, 1);
        chk("nowd_nowb", wb_valid, 0);
        chk("nowd_terr", timeout_err, 0);
        advance();
        flush = 1;
        advance();
        idle_inputs();
        sample();
        chk("nowd_flushed", stall, 0);
        advance();
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
